// File: rtl/pwm_core.sv
// PWM generator fed by the SPI register-write strobe. Period/duty/prescaler are
// shadowed and reload only at a period wrap, so register writes never glitch a pulse.
module pwm_core #(
   parameter int unsigned    DW         = 8,
   parameter logic [DW-1:0] RST_PERIOD = DW'('hFF),
   parameter logic [DW-1:0] RST_DUTY   = DW'('h80)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [1:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [1:0]    rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          pwm_out,
   output logic          period_end
);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESC  = 2'd1;
   localparam logic [1:0] A_PERIOD = 2'd2;
   localparam logic [1:0] A_DUTY   = 2'd3;

   logic [DW-1:0] ctrl, presc, period, duty;
   logic [DW-1:0] presc_s, period_s, duty_s;
   logic [DW-1:0] presc_cnt, cnt;
   logic          en, pol, tick;

   assign en   = ctrl[0];
   assign pol  = ctrl[1];
   assign tick = (presc_cnt == presc_s);

   // Live register file, written straight from the SPI strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl   <= '0;
         presc  <= '0;
         period <= RST_PERIOD;
         duty   <= RST_DUTY;
      end else if (wr_en) begin
         case (wr_addr)
            A_CTRL:   ctrl   <= wr_data;
            A_PRESC:  presc  <= wr_data;
            A_PERIOD: period <= wr_data;
            A_DUTY:   duty   <= wr_data;
            default:  ;
         endcase
      end
   end

   // Shadows sample pre-write live values, so a write on the wrap edge lands one period later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_s    <= '0;
         period_s   <= RST_PERIOD;
         duty_s     <= RST_DUTY;
         presc_cnt  <= '0;
         cnt        <= '0;
         pwm_out    <= 1'b0;
         period_end <= 1'b0;
      end else if (!en) begin
         presc_s    <= presc;
         period_s   <= period;
         duty_s     <= duty;
         presc_cnt  <= '0;
         cnt        <= '0;
         pwm_out    <= pol;
         period_end <= 1'b0;
      end else begin
         pwm_out <= pol ^ (cnt < duty_s);
         if (tick) begin
            presc_cnt <= '0;
            if (cnt == period_s) begin
               cnt        <= '0;
               presc_s    <= presc;
               period_s   <= period;
               duty_s     <= duty;
               period_end <= 1'b1;
            end else begin
               cnt        <= cnt + DW'(1);
               period_end <= 1'b0;
            end
         end else begin
            presc_cnt  <= presc_cnt + DW'(1);
            period_end <= 1'b0;
         end
      end
   end

   // Combinational read-back of the live registers.
   always_comb begin
      rd_data = '0;
      case (rd_addr)
         A_CTRL:   rd_data = ctrl;
         A_PRESC:  rd_data = presc;
         A_PERIOD: rd_data = period;
         A_DUTY:   rd_data = duty;
         default:  rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_pwm_core.sv
// Self-checking bench for pwm_core: directed scenarios plus random register traffic,
// compared against a period-position reference model.
module tb_pwm_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       pwm_out, period_end;

   pwm_core #(.DW(8), .RST_PERIOD(8'hFF), .RST_DUTY(8'h80)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_end(period_end)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int hi_cnt = 0;
   int pe_cnt = 0;
   bit chk_on = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: position k within the current period; cnt is k/(S+1).
   logic [7:0] m_live [4];
   int m_k, m_s, m_p, m_d, m_len;
   logic m_pwm, m_pe, m_pol;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_live[0] = 8'h00; m_live[1] = 8'h00; m_live[2] = 8'hFF; m_live[3] = 8'h80;
         m_s = 0; m_p = 255; m_d = 128; m_k = 0;
         m_pwm = 1'b0; m_pe = 1'b0;
      end else begin
         m_pol = m_live[0][1];
         if (!m_live[0][0]) begin
            m_pwm = m_pol;
            m_pe  = 1'b0;
            m_k   = 0;
            m_s = int'(m_live[1]); m_p = int'(m_live[2]); m_d = int'(m_live[3]);
         end else begin
            m_len = (m_p + 1) * (m_s + 1);
            m_pwm = m_pol ^ ((m_k / (m_s + 1)) < m_d);
            if (m_k == m_len - 1) begin
               m_pe = 1'b1;
               m_k  = 0;
               m_s = int'(m_live[1]); m_p = int'(m_live[2]); m_d = int'(m_live[3]);
            end else begin
               m_pe = 1'b0;
               m_k++;
            end
         end
         if (wr_en) m_live[wr_addr] = wr_data;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("pwm_out", 32'(pwm_out), 32'(m_pwm));
         check("period_end", 32'(period_end), 32'(m_pe));
         check("rd_data", 32'(rd_data), 32'(m_live[rd_addr]));
         if (pwm_out) hi_cnt++;
         if (period_end) pe_cnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_addr = a;
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      logic [7:0] exp_r [4];
      exp_r[0] = 8'h00; exp_r[1] = 8'h00; exp_r[2] = 8'hFF; exp_r[3] = 8'h80;
      for (int i = 0; i < 4; i++) begin
         rd_addr = 2'(i);
         #1;
         check(tag, 32'(rd_data), 32'(exp_r[i]));
      end
   endtask

   int a_hi, a_pe;
   bit found;

   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_pe", 32'(period_end), 32'd0);
      idle(3);
      rst = 1'b0;
      idle(1);
      check_regs("rst_regs");
      chk_on = 1'b1;

      // Basic PWM, no prescaler.
      wr(2, 8'd9); wr(3, 8'd3); wr(1, 8'd0); wr(0, 8'h01);
      idle(5);
      a_hi = hi_cnt; a_pe = pe_cnt;
      idle(30);
      check("p2_pe_count", 32'(pe_cnt - a_pe), 32'd3);
      check("p2_hi_count", 32'(hi_cnt - a_hi), 32'd9);

      // Prescaled period.
      wr(0, 8'h00);
      wr(2, 8'd4); wr(3, 8'd2); wr(1, 8'd2); wr(0, 8'h01);
      idle(7);
      a_hi = hi_cnt; a_pe = pe_cnt;
      idle(30);
      check("p3_pe_count", 32'(pe_cnt - a_pe), 32'd2);
      check("p3_hi_count", 32'(hi_cnt - a_hi), 32'd12);

      // Duty writes mid-period and on the exact wrap edge.
      wr(0, 8'h00);
      wr(2, 8'd9); wr(3, 8'd3); wr(1, 8'd0); wr(0, 8'h01);
      idle(13);
      wr(3, 8'd7);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_live[0][0] && m_k == (m_p + 1) * (m_s + 1) - 1) found = 1'b1;
         else idle(1);
      end
      check("wrap_seen", 32'(found), 32'd1);
      if (found) wr(3, 8'd5);
      a_hi = hi_cnt;
      idle(10);
      check("p4_hi_next", 32'(hi_cnt - a_hi), 32'd7);
      a_hi = hi_cnt;
      idle(10);
      check("p4_hi_later", 32'(hi_cnt - a_hi), 32'd5);

      // Duty boundaries and polarity.
      wr(3, 8'd0);
      idle(25);
      a_hi = hi_cnt;
      idle(20);
      check("duty0_hi", 32'(hi_cnt - a_hi), 32'd0);
      wr(3, 8'hFF);
      idle(12);
      a_hi = hi_cnt;
      idle(20);
      check("dutyff_hi", 32'(hi_cnt - a_hi), 32'd20);
      wr(0, 8'h03);
      idle(12);
      a_hi = hi_cnt;
      idle(20);
      check("dutyff_pol_hi", 32'(hi_cnt - a_hi), 32'd0);
      wr(0, 8'h02);
      idle(2);
      check("dis_pol_pwm", 32'(pwm_out), 32'd1);

      // Reset mid-period with POL=1.
      wr(3, 8'd3); wr(0, 8'h03);
      idle(13);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_pwm", 32'(pwm_out), 32'd0);
      check("mid_rst_pe", 32'(period_end), 32'd0);
      idle(2);
      rst = 1'b0;
      check_regs("post_rst_regs");
      a_hi = hi_cnt; a_pe = pe_cnt;
      idle(20);
      check("post_rst_hi", 32'(hi_cnt - a_hi), 32'd0);
      check("post_rst_pe", 32'(pe_cnt - a_pe), 32'd0);

      // Random register traffic.
      for (int i = 0; i < 3000; i++) begin
         rd_addr = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 20) begin
            logic [1:0] a;
            logic [7:0] d;
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            case (a)
               2'd0: d[0] = ($urandom_range(0, 9) != 0);
               2'd1: d = 8'($urandom_range(0, 3));
               default: if ($urandom_range(0, 19) != 0) d = 8'($urandom_range(0, 14));
            endcase
            wr(a, d);
         end else begin
            idle(1);
         end
      end

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
